mem_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-cache and data-cache request channels of the pipelined MIPS core. It grants one requester at a time with data-side priority and a bounded instruction-starvation guarantee. It holds the grant until RAM reports ACCESS, an abort, or a timeout. Sits between the caches and the RAM model/controller, below the pipeline control.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the I-cache and D-cache request channels.
// Data side has priority; the instruction side is forced after STARVE_LIM data grants.
module mem_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_e;

  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;

  logic dreq, ireq;
  logic access, rerr, tmo;
  logic gnt_act, rel, rel_d, rel_i;

  assign dreq    = dREN | dWEN;
  assign ireq    = iREN;
  assign access  = (ramstate == 2'b10);
  assign rerr    = (ramstate == 2'b11);
  assign tmo     = (wait_q == 8'(MAX_WAIT - 1));
  assign gnt_act = ((state_q == DSERV) && dreq) ||
                   ((state_q == ISERV) && ireq);
  assign rel     = gnt_act && (access || rerr || tmo);
  assign rel_d   = rel && (state_q == DSERV);
  assign rel_i   = rel && (state_q == ISERV);

  assign dwait   = dreq && !rel_d;
  assign iwait   = ireq && !rel_i;
  assign dload   = rel_d ? (access ? ramload : BAD_WORD) : '0;
  assign iload   = rel_i ? (access ? ramload : BAD_WORD) : '0;
  assign arb_err = err_q;

  // RAM port follows live requester inputs so a dropped request aborts at once
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    err_d    = err_q;
    if (state_q == IDLE) begin
      wait_d = '0;
      if (ireq && (starve_q == 4'(STARVE_LIM))) begin
        state_d  = ISERV;
        starve_d = '0;
      end else if (dreq) begin
        state_d = DSERV;
        if (ireq && (starve_q != 4'(STARVE_LIM)))
          starve_d = starve_q + 4'd1;
      end else if (ireq) begin
        state_d  = ISERV;
        starve_d = '0;
      end
    end else if (!gnt_act) begin
      state_d = IDLE;
    end else if (rel) begin
      state_d = IDLE;
      if (!access) err_d = 1'b1;
    end else begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a
// transaction-level model of owner, starvation count and service age.
module tb_mem_arbiter;

  localparam int LIM  = 4;
  localparam int MW   = 15;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_LIM(LIM), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // model: owner 0 none, 1 data, 2 instruction
  int m_own = 0, m_starve = 0, m_cyc = 0;
  bit m_err = 0;
  bit s_relD, s_relI, s_dreq, s_ireq;
  logic [1:0] s_rs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_cyc = 0; m_err = 0;
  endtask

  task automatic sample();
    bit dq, iq, lim, rD, rI;
    logic er, ew;
    logic [31:0] ea, es;
    @(negedge CLK);
    dq  = dREN | dWEN;
    iq  = iREN;
    lim = (m_cyc == MW - 1);
    rD  = (m_own == 1) && dq && (ramstate[1] || lim);
    rI  = (m_own == 2) && iq && (ramstate[1] || lim);
    er = 0; ew = 0; ea = 0; es = 0;
    if (m_own == 1) begin
      ew = dWEN; er = dREN && !dWEN; ea = daddr; es = dstore;
    end else if (m_own == 2) begin
      er = iREN; ea = iaddr;
    end
    chk("ramREN", ramREN, er);
    chk("ramWEN", ramWEN, ew);
    chk("ramaddr", ramaddr, ea);
    chk("ramstore", ramstore, es);
    chk("dwait", dwait, dq && !rD);
    chk("iwait", iwait, iq && !rI);
    chk("dload", dload, rD ? (ramstate == 2'b10 ? ramload : BAD) : 0);
    chk("iload", iload, rI ? (ramstate == 2'b10 ? ramload : BAD) : 0);
    chk("arb_err", arb_err, m_err);
    s_relD = rD; s_relI = rI; s_dreq = dq; s_ireq = iq; s_rs = ramstate;
  endtask

  task automatic adv();
    @(posedge CLK);
    if (m_own == 0) begin
      m_cyc = 0;
      if (s_ireq && m_starve == LIM) begin
        m_own = 2; m_starve = 0;
      end else if (s_dreq) begin
        m_own = 1;
        if (s_ireq && m_starve < LIM) m_starve++;
      end else if (s_ireq) begin
        m_own = 2; m_starve = 0;
      end
    end else if (!(m_own == 1 ? s_dreq : s_ireq)) begin
      m_own = 0;
    end else if (s_relD || s_relI) begin
      if (s_rs != 2'b10) m_err = 1;
      m_own = 0;
    end else begin
      m_cyc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    iREN = 0; dREN = 0; dWEN = 0;
    for (int k = 0; k < n; k++) begin
      sample(); adv();
    end
  endtask

  initial begin
    string got, expg;
    int n;
    bit found;
    nRST = 0; iREN = 1; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'b00;
    #2;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 0);
    chk("rst_iload", iload, 0);
    chk("rst_err", arb_err, 0);
    @(posedge CLK); #1;
    nRST = 1; iREN = 0;
    model_reset();

    // lone instruction read
    iREN = 1; iaddr = 32'h40; ramstate = 2'b10; ramload = 32'h8C010004;
    sample(); chk("lone_c0_ren", ramREN, 0); adv();
    sample();
    chk("lone_ren", ramREN, 1);
    chk("lone_addr", ramaddr, 32'h40);
    chk("lone_iwait", iwait, 0);
    chk("lone_iload", iload, 32'h8C010004);
    adv(); iREN = 0;
    sample(); chk("lone_c2_ren", ramREN, 0); adv();

    // contention
    dWEN = 1; daddr = 32'h100; dstore = 32'h12345678;
    iREN = 1; iaddr = 32'h44;
    sample(); adv();
    sample();
    chk("cont_wen", ramWEN, 1);
    chk("cont_store", ramstore, 32'h12345678);
    chk("cont_iwait", iwait, 1);
    adv(); dWEN = 0;
    sample(); chk("cont_turn", ramREN, 0); adv();
    sample();
    chk("cont_iren", ramREN, 1);
    chk("cont_iaddr", ramaddr, 32'h44);
    adv();
    idle(2);

    // starvation order
    dREN = 1; iREN = 1; daddr = 32'h200; iaddr = 32'h300;
    got = ""; expg = "DDDDIDDDDI";
    for (int k = 0; k < 20; k++) begin
      sample();
      if (ramREN === 1'b1) got = {got, (ramaddr == 32'h300) ? "I" : "D"};
      adv();
    end
    n_chk++;
    assert (got == expg) else begin
      n_fail++;
      $error("FAIL starve_order: got %s expected %s", got, expg);
    end
    idle(2);

    // abort
    dREN = 1; daddr = 32'h500; iaddr = 32'h600; ramstate = 2'b01;
    sample(); adv();
    sample(); chk("abort_c1_ren", ramREN, 1); adv();
    sample(); adv();
    dREN = 0; iREN = 1;
    sample(); chk("abort_c3_ren", ramREN, 0); adv();
    sample(); chk("abort_c4_ren", ramREN, 0); chk("abort_err", arb_err, 0);
    adv();
    sample(); chk("abort_c5_ren", ramREN, 1);
    chk("abort_c5_addr", ramaddr, 32'h600);
    adv();
    iREN = 0; idle(2);

    // timeout
    dREN = 1; daddr = 32'h700; ramstate = 2'b01;
    sample(); adv();
    n = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      sample();
      if (dwait === 1'b0) begin
        found = 1; n = k;
        chk("tmo_dload", dload, BAD);
      end
      adv();
    end
    chk("tmo_cycle", n, 15);
    dREN = 0;
    sample(); chk("tmo_err", arb_err, 1); adv();
    idle(3);
    chk("tmo_err_sticky", arb_err, 1);

    // async reset during instruction service
    iREN = 1; iaddr = 32'h800;
    sample(); adv();
    sample(); chk("ar_pre_ren", ramREN, 1); adv();
    #2 nRST = 0;
    #1;
    chk("ar_ren", ramREN, 0);
    chk("ar_err", arb_err, 0);
    iREN = 0; dREN = 1; daddr = 32'h900;
    nRST = 1;
    model_reset();
    sample(); chk("ar_idle_ren", ramREN, 0); adv();
    sample(); chk("ar_dgrant", ramREN, 1); chk("ar_daddr", ramaddr, 32'h900);
    adv();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      int r;
      dREN = 1'($urandom_range(0, 1));
      dWEN = ($urandom_range(0, 3) == 0);
      iREN = ($urandom_range(0, 2) != 0);
      daddr = $urandom; iaddr = $urandom; dstore = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 19);
      ramstate = (r < 10) ? 2'b10 : (r < 17) ? 2'b01 : (r < 19) ? 2'b00 : 2'b11;
      sample(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
